// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the interrupt controller.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        ISR,
        RETURN
    } int_state_e;

    localparam logic [31:0] DEFAULT_VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEFAULT_VEC_STRIDE = 32'd4;

    // Width of an IRQ index; at least one bit even for a single line.
    function automatic int unsigned cause_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Bundle of request/handshake signals between the pipeline and int_ctrl.
// slave = the controller, master = the pipeline side driving requests.
interface int_ctrl_if
    import int_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
);
    localparam int unsigned CW = cause_w(NUM_IRQ);

    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               global_ie;
    logic [31:0]        pc_if;
    logic               flush_in;
    logic               ret_valid;
    logic               INT_Detect;
    logic               INT_Return;
    logic               pc_redirect_valid;
    logic [31:0]        pc_redirect;
    logic [31:0]        epc;
    logic [CW-1:0]      int_cause;
    logic               in_isr;
    logic [NUM_IRQ-1:0] irq_ack;

    modport slave (
        input  irq_in, irq_mask, global_ie, pc_if, flush_in, ret_valid,
        output INT_Detect, INT_Return, pc_redirect_valid, pc_redirect,
               epc, int_cause, in_isr, irq_ack
    );

    modport master (
        output irq_in, irq_mask, global_ie, pc_if, flush_in, ret_valid,
        input  INT_Detect, INT_Return, pc_redirect_valid, pc_redirect,
               epc, int_cause, in_isr, irq_ack
    );

endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder.
module int_prio_enc
    import int_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = cause_w(N)
) (
    input  logic [N-1:0]  i_req,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    logic w_found;

    // Scan upward; the first set bit seen is the winner.
    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_req[i] && !w_found) begin
                w_found = 1'b1;
                o_idx   = IW'(i);
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches IRQ edges, drives the INT_Detect/INT_Return
// handshake to the stage registers and redirects fetch to/from the handler.
module int_ctrl
    import int_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [31:0] VEC_BASE   = DEFAULT_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEFAULT_VEC_STRIDE
) (
    input  logic       Clk,
    input  logic       Rst,
    int_ctrl_if.slave  bus
);

    localparam int unsigned CW = cause_w(NUM_IRQ);

    int_state_e         r_state;
    int_state_e         w_state_nxt;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_ack;
    logic [CW-1:0]      r_cause;
    logic [31:0]        r_epc;
    logic [31:0]        r_redirect;
    logic               r_redirect_valid;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_cause_onehot;
    logic [NUM_IRQ-1:0] w_pend_clr;
    logic               w_win_valid;
    logic [CW-1:0]      w_win_idx;
    logic               w_enter;
    logic               w_int_detect;
    logic               w_int_return;
    logic [31:0]        w_vec_addr;

    assign w_edge         = bus.irq_in & ~r_irq_prev;
    assign w_cause_onehot = NUM_IRQ'(1) << r_cause;
    assign w_pend_clr     = w_int_detect ? w_cause_onehot : '0;
    assign w_vec_addr     = VEC_BASE + 32'(r_cause) * VEC_STRIDE;

    int_prio_enc #(
        .N  (NUM_IRQ),
        .IW (CW)
    ) u_prio (
        .i_req   (r_pending & bus.irq_mask),
        .o_valid (w_win_valid),
        .o_idx   (w_win_idx)
    );

    // Next-state and combinational handshake outputs; flush suppresses both pulses.
    always_comb begin
        w_state_nxt  = r_state;
        w_enter      = 1'b0;
        w_int_detect = 1'b0;
        w_int_return = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.global_ie && w_win_valid) begin
                    w_enter     = 1'b1;
                    w_state_nxt = ENTER;
                end
            end
            ENTER: begin
                w_int_detect = ~bus.flush_in;
                if (w_int_detect) w_state_nxt = ISR;
            end
            ISR: begin
                if (bus.ret_valid && !bus.flush_in) w_state_nxt = RETURN;
            end
            RETURN: begin
                w_int_return = ~bus.flush_in;
                if (w_int_return) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Edge capture; a new edge on the line being acknowledged keeps it pending.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_irq_prev <= bus.irq_in;
            r_pending  <= (r_pending & ~w_pend_clr) | w_edge;
        end
    end

    // Cause is frozen on IDLE->ENTER so later mask/enable changes cannot alter it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)          r_cause <= '0;
        else if (w_enter) r_cause <= w_win_idx;
    end

    // Resume PC, acknowledge pulse and fetch redirect pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_epc            <= '0;
            r_ack            <= '0;
            r_redirect       <= '0;
            r_redirect_valid <= 1'b0;
        end else begin
            r_ack            <= '0;
            r_redirect_valid <= 1'b0;
            if (w_int_detect) begin
                r_epc            <= bus.pc_if;
                r_ack            <= w_cause_onehot;
                r_redirect       <= w_vec_addr;
                r_redirect_valid <= 1'b1;
            end else if (w_int_return) begin
                r_redirect       <= r_epc;
                r_redirect_valid <= 1'b1;
            end
        end
    end

    assign bus.INT_Detect        = w_int_detect;
    assign bus.INT_Return        = w_int_return;
    assign bus.pc_redirect_valid = r_redirect_valid;
    assign bus.pc_redirect       = r_redirect;
    assign bus.epc               = r_epc;
    assign bus.int_cause         = r_cause;
    assign bus.in_isr            = (r_state == ISR) || (r_state == RETURN);
    assign bus.irq_ack           = r_ack;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: stimulus pushes expected pulses, a monitor pops them.
module tb_int_ctrl;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    always #5 Clk = ~Clk;

    int_ctrl_if #(.NUM_IRQ(8)) bus ();

    int_ctrl #(
        .NUM_IRQ    (8),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'd4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // kind: 0 = INT_Detect, 1 = pc redirect, 2 = INT_Return
    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [7:0]  ack;
        logic [2:0]  cause;
        logic [31:0] epc;
        logic        isr;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_det(input logic [2:0] c);
        exp_t e;
        e = '{kind: 0, pc: '0, ack: '0, cause: c, epc: '0, isr: 1'b0};
        q.push_back(e);
    endtask

    task automatic push_redir(input logic [31:0] pc, input logic [7:0] ack,
                              input logic [31:0] epc, input logic isr);
        exp_t e;
        e = '{kind: 1, pc: pc, ack: ack, cause: '0, epc: epc, isr: isr};
        q.push_back(e);
    endtask

    task automatic push_ret();
        exp_t e;
        e = '{kind: 2, pc: '0, ack: '0, cause: '0, epc: '0, isr: 1'b0};
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (q.size() == 0) done = 1;
            else tick();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_%s: %0d expected events outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic pulse_ret();
        bus.ret_valid = 1'b1;
        tick();
        bus.ret_valid = 1'b0;
    endtask

    // Monitor: compare every pulse the DUT presents against the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (bus.INT_Detect || bus.INT_Return) begin
                chk("det_ret_exclusive", 32'(bus.INT_Detect & bus.INT_Return), 0);
                chk("pulse_under_flush", 32'(bus.flush_in), 0);
            end
            if (bus.INT_Detect) begin
                if (q.size() == 0) chk("unexpected_INT_Detect", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("det_kind", 32'(0), 32'(e.kind));
                    chk("det_cause", 32'(bus.int_cause), 32'(e.cause));
                end
            end
            if (bus.INT_Return) begin
                if (q.size() == 0) chk("unexpected_INT_Return", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("ret_kind", 32'(2), 32'(e.kind));
                end
            end
            if (bus.pc_redirect_valid) begin
                if (q.size() == 0) chk("unexpected_redirect", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("redir_kind", 32'(1), 32'(e.kind));
                    chk("redir_pc", bus.pc_redirect, e.pc);
                    chk("redir_ack", 32'(bus.irq_ack), 32'(e.ack));
                    chk("redir_epc", bus.epc, e.epc);
                    chk("redir_in_isr", 32'(bus.in_isr), 32'(e.isr));
                end
            end else if (bus.irq_ack != 0) begin
                chk("ack_without_redirect", 32'(bus.irq_ack), 0);
            end
        end
    end

    initial begin
        bus.irq_in    = '0;
        bus.irq_mask  = '0;
        bus.global_ie = 1'b0;
        bus.pc_if     = '0;
        bus.flush_in  = 1'b0;
        bus.ret_valid = 1'b0;
        #12;
        chk("rst_INT_Detect", 32'(bus.INT_Detect), 0);
        chk("rst_INT_Return", 32'(bus.INT_Return), 0);
        chk("rst_redirect_valid", 32'(bus.pc_redirect_valid), 0);
        chk("rst_pc_redirect", bus.pc_redirect, 0);
        chk("rst_epc", bus.epc, 0);
        chk("rst_int_cause", 32'(bus.int_cause), 0);
        chk("rst_in_isr", 32'(bus.in_isr), 0);
        chk("rst_irq_ack", 32'(bus.irq_ack), 0);
        tick();
        Rst = 1'b0;
        bus.irq_mask  = 8'hFF;
        bus.global_ie = 1'b1;
        bus.pc_if     = 32'h40;
        tick();

        // T1: IRQ 3 entry
        push_det(3'd3);
        push_redir(32'h10C, 8'h08, 32'h40, 1'b1);
        bus.irq_in = 8'h08;
        drain("t1");
        tick();
        chk("t1_valid_drops", 32'(bus.pc_redirect_valid), 0);
        chk("t1_ack_drops", 32'(bus.irq_ack), 0);
        chk("t1_in_isr", 32'(bus.in_isr), 1);
        bus.irq_in = '0;

        // T2: return to 0x40
        push_ret();
        push_redir(32'h40, 8'h00, 32'h40, 1'b0);
        pulse_ret();
        drain("t2");
        tick();
        chk("t2_in_isr", 32'(bus.in_isr), 0);
        chk("t2_valid_drops", 32'(bus.pc_redirect_valid), 0);

        // T3: IRQ 2 and 5 together, 2 first, 5 right after return
        bus.pc_if = 32'h200;
        push_det(3'd2);
        push_redir(32'h108, 8'h04, 32'h200, 1'b1);
        bus.irq_in = 8'h24;
        drain("t3a");
        bus.irq_in = '0;
        push_ret();
        push_redir(32'h200, 8'h00, 32'h200, 1'b0);
        push_det(3'd5);
        push_redir(32'h114, 8'h20, 32'h200, 1'b1);
        pulse_ret();
        drain("t3b");
        push_ret();
        push_redir(32'h200, 8'h00, 32'h200, 1'b0);
        pulse_ret();
        drain("t3c");

        // T4: flush holds ENTER and RETURN for 3 cycles
        bus.pc_if    = 32'h300;
        bus.irq_in   = 8'h01;
        bus.flush_in = 1'b1;
        tick();
        tick();
        chk("t4_det_flush1", 32'(bus.INT_Detect), 0);
        tick();
        chk("t4_det_flush2", 32'(bus.INT_Detect), 0);
        tick();
        chk("t4_det_flush3", 32'(bus.INT_Detect), 0);
        chk("t4_not_in_isr", 32'(bus.in_isr), 0);
        tick();
        push_det(3'd0);
        push_redir(32'h100, 8'h01, 32'h300, 1'b1);
        bus.flush_in = 1'b0;
        drain("t4a");
        bus.irq_in = '0;
        bus.ret_valid = 1'b1;
        tick();
        bus.ret_valid = 1'b0;
        bus.flush_in  = 1'b1;
        #1;
        chk("t4_ret_flush1", 32'(bus.INT_Return), 0);
        tick();
        chk("t4_ret_flush2", 32'(bus.INT_Return), 0);
        chk("t4_ret_in_isr", 32'(bus.in_isr), 1);
        tick();
        chk("t4_ret_flush3", 32'(bus.INT_Return), 0);
        tick();
        push_ret();
        push_redir(32'h300, 8'h00, 32'h300, 1'b0);
        bus.flush_in = 1'b0;
        drain("t4b");

        // T5: masked line waits, then enters; global_ie=0 blocks entry
        bus.pc_if    = 32'h400;
        bus.irq_mask = 8'hFD;
        bus.irq_in   = 8'h02;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_masked_in_isr", 32'(bus.in_isr), 0);
        push_det(3'd1);
        push_redir(32'h104, 8'h02, 32'h400, 1'b1);
        bus.irq_mask = 8'hFF;
        drain("t5a");
        bus.irq_in = '0;
        push_ret();
        push_redir(32'h400, 8'h00, 32'h400, 1'b0);
        pulse_ret();
        drain("t5b");
        bus.global_ie = 1'b0;
        tick();
        bus.irq_in = 8'h10;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_ie0_in_isr", 32'(bus.in_isr), 0);
        push_det(3'd4);
        push_redir(32'h110, 8'h10, 32'h400, 1'b1);
        bus.global_ie = 1'b1;
        drain("t5c");
        tick();
        chk("t6_pre_in_isr", 32'(bus.in_isr), 1);

        // T6: reset while in ISR
        Rst = 1'b1;
        #1;
        chk("t6_INT_Detect", 32'(bus.INT_Detect), 0);
        chk("t6_INT_Return", 32'(bus.INT_Return), 0);
        chk("t6_redirect_valid", 32'(bus.pc_redirect_valid), 0);
        chk("t6_pc_redirect", bus.pc_redirect, 0);
        chk("t6_epc", bus.epc, 0);
        chk("t6_int_cause", 32'(bus.int_cause), 0);
        chk("t6_in_isr", 32'(bus.in_isr), 0);
        chk("t6_irq_ack", 32'(bus.irq_ack), 0);
        bus.irq_in = '0;
        tick();
        Rst = 1'b0;
        bus.ret_valid = 1'b1;
        tick();
        bus.ret_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_post_in_isr", 32'(bus.in_isr), 0);
        chk("t6_post_epc", bus.epc, 0);

        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
